multicycle_control: RTL

Multicycle control unit for the ARM datapath, generalising the single-cycle instruction decoder into a sequenced FSM with a flag register, condition-check logic and an optional memory-ready handshake. It takes the fields of the instruction register, ALU flags and memory status, and drives every datapath enable and mux select cycle by cycle. The ALU control width and the extended data-processing set (EOR, CMP, MOV) are parametrised.

---
 rtl/multicycle_control.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Multicycle ARM control unit: instruction sequencing FSM, NZCV flag
// register, condition check and optional memory-ready handshake.
module multicycle_control #(
  parameter int unsigned ALUC_W        = 3,
  parameter int unsigned EXT_OPS       = 1,
  parameter int unsigned MEM_HANDSHAKE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        Cond,
  input  logic [1:0]        Op,
  input  logic [5:0]        Funct,
  input  logic [3:0]        Rd,
  input  logic [3:0]        ALUFlags,
  input  logic              MemReady,
  output logic              PCWrite,
  output logic              MemWrite,
  output logic              RegWrite,
  output logic              IRWrite,
  output logic              AdrSrc,
  output logic [1:0]        ResultSrc,
  output logic [1:0]        ALUSrcA,
  output logic [1:0]        ALUSrcB,
  output logic [1:0]        ImmSrc,
  output logic [1:0]        RegSrc,
  output logic [ALUC_W-1:0] ALUControl,
  output logic [3:0]        Flags,
  output logic              IllegalOp
);

  localparam bit EXT = (EXT_OPS != 0);

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_ORR = 3'd3;
  localparam logic [2:0] ALU_EOR = 3'd4;
  localparam logic [2:0] ALU_MOV = 3'd5;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
    S_MEMWRITE, S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] flags_q, flags_d;

  logic       mem_done;
  logic       cond_ex;
  logic       dp_legal, is_cmp, add_sub;
  logic [2:0] dp_alu, alu_sel;
  logic       pc_write, mem_write, reg_write, ir_write, illegal;
  logic       n_f, z_f, c_f, v_f;

  assign mem_done = (MEM_HANDSHAKE == 0) || MemReady;
  assign {n_f, z_f, c_f, v_f} = flags_q;

  // State and flag registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  // Data-processing command decode from Funct[4:1]
  always_comb begin
    dp_alu   = ALU_ADD;
    dp_legal = 1'b1;
    is_cmp   = 1'b0;
    add_sub  = 1'b0;
    case (Funct[4:1])
      4'b0100: begin dp_alu = ALU_ADD; add_sub = 1'b1; end
      4'b0010: begin dp_alu = ALU_SUB; add_sub = 1'b1; end
      4'b0000: dp_alu = ALU_AND;
      4'b1100: dp_alu = ALU_ORR;
      4'b0001: begin
        if (EXT) dp_alu = ALU_EOR;
        else     dp_legal = 1'b0;
      end
      4'b1010: begin
        if (EXT && Funct[0]) begin
          dp_alu  = ALU_SUB;
          is_cmp  = 1'b1;
          add_sub = 1'b1;
        end else begin
          dp_legal = 1'b0;
        end
      end
      4'b1101: begin
        if (EXT) dp_alu = ALU_MOV;
        else     dp_legal = 1'b0;
      end
      default: dp_legal = 1'b0;
    endcase
  end

  // ARM condition evaluation against the flag register
  always_comb begin
    cond_ex = 1'b0;
    case (Cond)
      4'h0: cond_ex = z_f;
      4'h1: cond_ex = !z_f;
      4'h2: cond_ex = c_f;
      4'h3: cond_ex = !c_f;
      4'h4: cond_ex = n_f;
      4'h5: cond_ex = !n_f;
      4'h6: cond_ex = v_f;
      4'h7: cond_ex = !v_f;
      4'h8: cond_ex = c_f && !z_f;
      4'h9: cond_ex = !c_f || z_f;
      4'hA: cond_ex = (n_f == v_f);
      4'hB: cond_ex = (n_f != v_f);
      4'hC: cond_ex = !z_f && (n_f == v_f);
      4'hD: cond_ex = z_f || (n_f != v_f);
      4'hE: cond_ex = 1'b1;
      4'hF: cond_ex = 1'b0;
      default: cond_ex = 1'b0;
    endcase
  end

  // Flag update at the end of an EXECUTE cycle
  always_comb begin
    flags_d = flags_q;
    if (state_q == S_EXECUTER || state_q == S_EXECUTEI) begin
      if (Funct[0])            flags_d[3:2] = ALUFlags[3:2];
      if (Funct[0] && add_sub) flags_d[1:0] = ALUFlags[1:0];
    end
  end

  // Next-state and per-state datapath controls
  always_comb begin
    state_d   = state_q;
    pc_write  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    ir_write  = 1'b0;
    illegal   = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    alu_sel   = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        ir_write  = mem_done;
        pc_write  = mem_done;
        if (mem_done) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (!cond_ex) begin
          state_d = S_FETCH;
        end else if (Op == 2'b11 || (Op == 2'b00 && !dp_legal)) begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end else if (Op == 2'b01) begin
          state_d = S_MEMADR;
        end else if (Op == 2'b10) begin
          state_d = S_BRANCH;
        end else if (Funct[5]) begin
          state_d = S_EXECUTEI;
        end else begin
          state_d = S_EXECUTER;
        end
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
        state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_done) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_write = 1'b1;
        pc_write  = (Rd == 4'd15);
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
        if (mem_done) state_d = S_FETCH;
      end
      S_EXECUTER: begin
        alu_sel = dp_alu;
        state_d = is_cmp ? S_FETCH : S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcB = 2'b01;
        alu_sel = dp_alu;
        state_d = is_cmp ? S_FETCH : S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = (Rd != 4'd15);
        pc_write  = (Rd == 4'd15);
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        pc_write  = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Op-derived immediate and register-source selects
  always_comb begin
    ImmSrc = 2'b00;
    RegSrc = 2'b00;
    case (Op)
      2'b01: begin
        ImmSrc = 2'b01;
        RegSrc = Funct[0] ? 2'b00 : 2'b10;
      end
      2'b10: begin
        ImmSrc = 2'b10;
        RegSrc = 2'b01;
      end
      default: begin
        ImmSrc = 2'b00;
        RegSrc = 2'b00;
      end
    endcase
  end

  // Write enables are suppressed for the whole time reset is held
  assign PCWrite    = pc_write  & reset;
  assign MemWrite   = mem_write & reset;
  assign RegWrite   = reg_write & reset;
  assign IRWrite    = ir_write  & reset;
  assign IllegalOp  = illegal   & reset;
  assign ALUControl = ALUC_W'(alu_sel);
  assign Flags      = flags_q;

endmodule
